// File: rtl/alu_seq_core.sv
// Registered, handshaked execute ALU with an iterative restoring divider.
// Optional status flags (zero/neg/carry) are compiled in when ALU_FLAGS_EN is defined.
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 7,
  parameter int OPC_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic [RD_W-1:0]  rd,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rsi,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RD_W-1:0]  rd_out,
  output logic [RD_W-1:0]  branch_target,
  output logic [OPC_W-1:0] opcode_out,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             illegal_op
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LV   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MLT  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_REST = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SUM  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_CP   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_B    = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BEG  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SLR  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_GP   = OPC_W'(10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [RD_W-1:0]   rd_out_q, rd_out_d;
  logic [RD_W-1:0]   bt_q, bt_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              dbz_q, dbz_d;
  logic              ill_q, ill_d;

  // Divider: dvd_q starts as the dividend and shifts into the quotient.
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0]  op_result;
  logic [RD_W-1:0]   op_rd;
  logic [RD_W-1:0]   op_bt;
  logic [OPC_W-1:0]  op_opc;
  logic              op_dbz;
  logic              op_ill;
  logic [WIDTH-1:0]  rd_ext;

  logic              accept;
  logic              start_div;
  logic              div_last;
  logic [WIDTH:0]    div_trial;
  logic [WIDTH:0]    div_diff;
  logic              div_fits;
  logic [WIDTH-1:0]  div_rem_next;
  logic [WIDTH-1:0]  div_quo_next;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign start_div = (opcode == OP_DIV) & (rt != '0);
  assign div_last  = (state_q == S_DIV_RUN) & (cnt_q == CNT_LAST);
  assign rd_ext    = {{(WIDTH-RD_W){1'b0}}, rd};

  // Single-cycle operations; DIV here only covers the divide-by-zero case.
  always_comb begin
    op_result = '0;
    op_rd     = '0;
    op_bt     = '0;
    op_opc    = opcode;
    op_dbz    = 1'b0;
    op_ill    = 1'b0;
    case (opcode)
      OP_NOP: op_opc = '0;
      OP_LV, OP_CP: begin
        op_result = rsi;
        op_rd     = rd;
      end
      OP_MLT: begin
        op_result = rs * rt;
        op_rd     = rd;
      end
      OP_DIV: begin
        op_rd = rd;
        if (rt == '0) begin
          op_result = '1;
          op_dbz    = 1'b1;
        end
      end
      OP_REST: begin
        op_result = rs - rt;
        op_rd     = rd;
      end
      OP_SUM: begin
        op_result = rs + rt;
        op_rd     = rd;
      end
      OP_B: op_bt = rd;
      OP_BEG: begin
        op_result = {{(WIDTH-1){1'b0}}, (rd_ext > rs)};
        op_bt     = rt[RD_W-1:0];
      end
      OP_SLR: begin
        op_result = (rt >= WIDTH_V) ? '0 : (rs << rt);
        op_rd     = rd;
      end
      OP_GP: begin
        op_result = rs;
        op_rd     = rd;
      end
      default: op_ill = 1'b1;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_trial    = {rem_q, dvd_q[WIDTH-1]};
    div_diff     = div_trial - {1'b0, dvs_q};
    div_fits     = (div_trial >= {1'b0, dvs_q});
    div_rem_next = div_fits ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quo_next = {dvd_q[WIDTH-2:0], div_fits};
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    rd_out_d    = rd_out_q;
    bt_d        = bt_q;
    opc_d       = opc_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    ill_d       = ill_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (start_div) begin
            state_d     = S_DIV_RUN;
            out_valid_d = 1'b0;
            rd_out_d    = rd;
            bt_d        = '0;
            opc_d       = opcode;
            dbz_d       = 1'b0;
            ill_d       = 1'b0;
            dvd_d       = rs;
            dvs_d       = rt;
            rem_d       = '0;
            cnt_d       = '0;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            rd_out_d    = op_rd;
            bt_d        = op_bt;
            opc_d       = op_opc;
            result_d    = op_result;
            dbz_d       = op_dbz;
            ill_d       = op_ill;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      S_DIV_RUN: begin
        dvd_d = div_quo_next;
        rem_d = div_rem_next;
        cnt_d = cnt_q + 1'b1;
        if (div_last) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = div_quo_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic zf_q, zf_d;
  logic nf_q, nf_d;
  logic cf_q, cf_d;
  logic op_carry;
  logic flag_load;

  // SUM overflowed iff the truncated sum wrapped below an operand.
  assign op_carry  = ((opcode == OP_SUM) & (op_result < rs)) |
                     ((opcode == OP_REST) & (rs < rt));
  assign flag_load = div_last | (accept & ~start_div);

  always_comb begin
    zf_d = zf_q;
    nf_d = nf_q;
    cf_d = cf_q;
    if (flag_load) begin
      zf_d = (result_d == '0);
      nf_d = result_d[WIDTH-1];
      cf_d = div_last ? 1'b0 : op_carry;
    end
  end

  assign zero_flag  = zf_q;
  assign neg_flag   = nf_q;
  assign carry_flag = cf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      rd_out_q    <= '0;
      bt_q        <= '0;
      opc_q       <= '0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      ill_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
`ifdef ALU_FLAGS_EN
      zf_q        <= 1'b0;
      nf_q        <= 1'b0;
      cf_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rd_out_q    <= rd_out_d;
      bt_q        <= bt_d;
      opc_q       <= opc_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
      ill_q       <= ill_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
`ifdef ALU_FLAGS_EN
      zf_q        <= zf_d;
      nf_q        <= nf_d;
      cf_q        <= cf_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign rd_out        = rd_out_q;
  assign branch_target = bt_q;
  assign opcode_out    = opc_q;
  assign result        = result_q;
  assign div_by_zero   = dbz_q;
  assign illegal_op    = ill_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomised and directed bench for alu_seq_core against a transaction-level model.
// Flag outputs are checked when ALU_FLAGS_EN is defined.
module tb_alu_seq_core;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  opcode = '0;
  logic [6:0]  rd = '0;
  logic [31:0] rs = '0, rsi = '0, rt = '0;
  logic        in_ready, out_valid, div_by_zero, illegal_op;
  logic [6:0]  rd_out, branch_target;
  logic [4:0]  opcode_out;
  logic [31:0] result;
`ifdef ALU_FLAGS_EN
  logic        zero_flag, neg_flag, carry_flag;
`endif

  alu_seq_core #(.WIDTH(32), .RD_W(7), .OPC_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rsi(rsi), .rt(rt),
    .out_valid(out_valid), .out_ready(out_ready), .rd_out(rd_out),
    .branch_target(branch_target), .opcode_out(opcode_out), .result(result),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
`ifdef ALU_FLAGS_EN
    , .zero_flag(zero_flag), .neg_flag(neg_flag), .carry_flag(carry_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  rd_out;
    logic [6:0]  bt;
    logic [4:0]  opc;
    logic [31:0] res;
    logic        dbz, ill, zf, nf, cf;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int or_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0
  bit started = 1'b0;

  bit   m_valid = 1'b0;
  int   m_div_wait = 0;
  exp_t m_exp, m_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int op, input logic [6:0] r,
                                 input logic [31:0] a, input logic [31:0] ai, input logic [31:0] b);
    exp_t e;
    longint unsigned p;
    e.rd_out = '0; e.bt = '0; e.opc = 5'(op); e.res = '0;
    e.dbz = 0; e.ill = 0; e.cf = 0;
    case (op)
      0: e.opc = '0;
      1, 6: e.res = ai;
      2: begin p = longint'(a) * longint'(b); e.res = p[31:0]; end
      3: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.dbz = 1; end else e.res = a / b;
      4: begin e.res = a - b; e.cf = (a < b); end
      5: begin p = longint'(a) + longint'(b); e.res = p[31:0]; e.cf = p[32]; end
      7: e.bt = r;
      8: begin e.res = (int'(r) > longint'(a)) ? 1 : 0; e.bt = b[6:0]; end
      9: e.res = (b >= 32) ? 32'd0 : (a << b);
      10: e.res = a;
      default: e.ill = 1;
    endcase
    if (op inside {[1:6], 9, 10}) e.rd_out = r;
    e.zf = (e.res == 0);
    e.nf = e.res[31];
    return e;
  endfunction

  // Transaction-level model: advances on each clock edge from the bench's own inputs.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_valid = 0;
      m_div_wait = 0;
    end else if (m_div_wait > 0) begin
      m_div_wait--;
      if (m_div_wait == 0) begin
        m_valid = 1;
        m_exp = m_pend;
      end
    end else if (in_valid && (!m_valid || out_ready)) begin
      if (opcode == 3 && rt != 0) begin
        m_pend = model(int'(opcode), rd, rs, rsi, rt);
        m_div_wait = WIDTH;
        m_valid = 0;
      end else begin
        m_exp = model(int'(opcode), rd, rs, rsi, rt);
        m_valid = 1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (started && !rst) begin
      chk("in_ready", in_ready, (m_div_wait == 0) && (!m_valid || out_ready));
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("result", result, m_exp.res);
        chk("rd_out", rd_out, m_exp.rd_out);
        chk("branch_target", branch_target, m_exp.bt);
        chk("opcode_out", opcode_out, m_exp.opc);
        chk("div_by_zero", div_by_zero, m_exp.dbz);
        chk("illegal_op", illegal_op, m_exp.ill);
`ifdef ALU_FLAGS_EN
        chk("zero_flag", zero_flag, m_exp.zf);
        chk("neg_flag", neg_flag, m_exp.nf);
        chk("carry_flag", carry_flag, m_exp.cf);
`endif
        if (out_ready)
          $display("txn opc=%0d rd_out=%0d bt=%0d result=%08h dbz=%0b ill=%0b",
                   opcode_out, rd_out, branch_target, result, div_by_zero, illegal_op);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (or_mode == 0);
  end

  task automatic drive_op(input int op, input logic [6:0] r,
                          input logic [31:0] a, input logic [31:0] ai, input logic [31:0] b);
    bit done = 0;
    @(negedge clk);
    in_valid = 1; opcode = 5'(op); rd = r; rs = a; rsi = ai; rt = b;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (in_ready === 1'b1) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept for op %0d", op);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    #3;
  endtask

  initial begin
    exp_t e;
    int cyc;
    bit saw;
    time t0;
    int op;
    logic [31:0] a, b;

    // Pin the model against hand-computed values.
    e = model(5, 7'd3, 32'd7, 32'd0, 32'd5);       chk("model_sum", e.res, 32'd12);
    e = model(3, 7'd0, 32'd100, 32'd0, 32'd7);     chk("model_div", e.res, 32'd14);
    e = model(3, 7'd0, 32'd100, 32'd0, 32'd0);     chk("model_div0", e.res, 32'hFFFF_FFFF);
    e = model(8, 7'd9, 32'd4, 32'd0, 32'h15);      chk("model_beg", {e.res, 25'd0, e.bt}, {32'd1, 25'd0, 7'h15});

    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_opcode_out", opcode_out, 0);
    rst = 0;
    started = 1;
    sample();
    chk("post_rst_in_ready", in_ready, 1);

    drive_op(5, 7'd3, 32'd7, 32'd0, 32'd5); idle(); #3;
    chk("sum_valid", out_valid, 1);
    chk("sum_result", result, 32'd12);
    chk("sum_rd_out", rd_out, 7'd3);
    chk("sum_bt", branch_target, 0);

    drive_op(3, 7'd4, 32'd100, 32'd0, 32'd7); idle(); #3;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      chk("div_busy_in_ready", in_ready, 0);
      sample();
      cyc++;
    end
    chk("div_latency", cyc, 33);
    chk("div_result", result, 32'd14);

    drive_op(3, 7'd4, 32'd100, 32'd0, 32'd0); idle(); #3;
    chk("div0_result", result, 32'hFFFF_FFFF);
    chk("div0_flag", div_by_zero, 1);
    drive_op(9, 7'd2, 32'd1, 32'd0, 32'd40); idle(); #3;
    chk("slr_big", result, 0);
    drive_op(8, 7'd9, 32'd4, 32'd0, 32'h15); idle(); #3;
    chk("beg_result", result, 1);
    chk("beg_bt", branch_target, 7'h15);
    chk("beg_rd_out", rd_out, 0);
    drive_op(12, 7'd5, 32'd1, 32'd2, 32'd3); idle(); #3;
    chk("illegal_flag", illegal_op, 1);
    chk("illegal_opc", opcode_out, 12);

    or_mode = 2;
    drive_op(5, 7'd1, 32'd7, 32'd0, 32'd5); idle();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 32'd12);
      chk("hold_in_ready", in_ready, 0);
    end
    or_mode = 0;
    drive_op(5, 7'd1, 32'd1, 32'd0, 32'd2);
    t0 = $time;
    drive_op(5, 7'd2, 32'd3, 32'd0, 32'd4);
    drive_op(5, 7'd3, 32'd5, 32'd0, 32'd6);
    drive_op(5, 7'd4, 32'd7, 32'd0, 32'd8);
    chk("back_to_back_time", $time - t0, 30);
    idle(); #3;
    chk("b2b_last_result", result, 32'd15);

    drive_op(3, 7'd6, 32'd1000, 32'd0, 32'd3); idle();
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (out_valid) saw = 1;
    end
    chk("rst_mid_div_no_valid", saw, 0);
    drive_op(5, 7'd2, 32'd1, 32'd0, 32'd1); idle(); #3;
    chk("sum_after_rst", result, 32'd2);
`ifdef ALU_FLAGS_EN
    drive_op(5, 7'd2, 32'hFFFF_FFFF, 32'd0, 32'd1); idle(); #3;
    chk("flags_sum_result", result, 0);
    chk("flags_zero", zero_flag, 1);
    chk("flags_carry", carry_flag, 1);
`endif

    or_mode = 1;
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) idle();
      op = $urandom_range(0, 15);
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 200));
      drive_op(op, 7'($urandom_range(0, 127)), a, $urandom, b);
    end
    idle();
    or_mode = 0;
    repeat (50) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
